// File: rtl/fft_frame_scheduler_pkg.sv
// rtl/fft_frame_scheduler_pkg.sv - shared state type and constants for the FFT frame scheduler
package fft_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    LOAD,
    STREAM
  } sched_state_t;

  localparam int DEF_ADDR_BITS = 9;
  localparam int FRAME_LEN = 2 ** DEF_ADDR_BITS;
  localparam logic [1:0] SINK_ERR_NONE = 2'b00;

endpackage

// File: rtl/fft_frame_scheduler_rr_arbiter.sv
// rtl/fft_frame_scheduler_rr_arbiter.sv - combinational round-robin pick starting at the pointer
module rr_arbiter
  import fft_sched_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [$clog2(NUM_CH)-1:0] ptr_i,
  output logic [NUM_CH-1:0]         grant_o,
  output logic [$clog2(NUM_CH)-1:0] idx_o,
  output logic                      valid_o
);
  localparam int SEL_BITS = $clog2(NUM_CH);

  logic [SEL_BITS-1:0] cand;

  // Scan farthest-from-pointer first so the closest requester is written last and wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = SEL_BITS'((int'(ptr_i) + i) % NUM_CH);
      if (req_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - round-robin scheduler streaming one channel frame at a time into the FFT sink
module fft_frame_scheduler
  import fft_sched_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           ch_req,
  output logic [NUM_CH-1:0]           ch_grant,
  output logic [NUM_CH-1:0]           ch_done,
  output logic [$clog2(NUM_CH)-1:0]   rd_sel,
  output logic [ADDR_BITS-1:0]        rd_addr,
  input  logic signed [DATA_BITS-1:0] rd_data,
  output logic                        sink_valid,
  input  logic                        sink_ready,
  output logic                        sink_sop,
  output logic                        sink_eop,
  output logic signed [DATA_BITS-1:0] sink_real,
  output logic signed [DATA_BITS-1:0] sink_imag,
  output logic [1:0]                  sink_error,
  output logic                        busy,
  output logic [15:0]                 frames_done
);
  localparam int SEL_BITS = $clog2(NUM_CH);
  localparam logic [SEL_BITS-1:0] LAST_CH  = SEL_BITS'(NUM_CH - 1);
  localparam logic [ADDR_BITS:0]  LAST_IDX = {1'b0, {ADDR_BITS{1'b1}}};
  localparam logic [ADDR_BITS:0]  ONE_IDX  = {{ADDR_BITS{1'b0}}, 1'b1};

  sched_state_t                state_q;
  logic [NUM_CH-1:0]           grant_q;
  logic [NUM_CH-1:0]           done_q;
  logic [SEL_BITS-1:0]         sel_q;
  logic [SEL_BITS-1:0]         ptr_q;
  logic [SEL_BITS-1:0]         ptr_d;
  logic [ADDR_BITS:0]          idx_q;
  logic [ADDR_BITS:0]          idx_d;
  logic                        valid_q;
  logic                        sop_q;
  logic                        eop_q;
  logic                        busy_q;
  logic signed [DATA_BITS-1:0] real_q;
  logic [15:0]                 frames_q;

  logic [NUM_CH-1:0]   arb_grant;
  logic [SEL_BITS-1:0] arb_idx;
  logic                arb_valid;
  logic                beat;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i   (ch_req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign beat  = valid_q & sink_ready;
  assign idx_d = idx_q + {{ADDR_BITS{1'b0}}, beat};
  assign ptr_d = (sel_q == LAST_CH) ? '0 : sel_q + SEL_BITS'(1);

  // Look one address ahead on a beat so rd_data holds mem[idx] at every edge.
  always_comb begin
    rd_addr = '0;
    case (state_q)
      LOAD:    rd_addr = ONE_IDX[ADDR_BITS-1:0];
      STREAM:  rd_addr = idx_d[ADDR_BITS-1:0];
      default: rd_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      sel_q    <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      busy_q   <= 1'b0;
      real_q   <= '0;
      frames_q <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            grant_q <= arb_grant;
            sel_q   <= arb_idx;
            busy_q  <= 1'b1;
            state_q <= PRIME;
          end
        end
        PRIME: state_q <= LOAD;
        LOAD: begin
          real_q  <= rd_data;
          valid_q <= 1'b1;
          sop_q   <= 1'b1;
          idx_q   <= ONE_IDX;
          state_q <= STREAM;
        end
        STREAM: begin
          if (beat) begin
            if (eop_q) begin
              valid_q  <= 1'b0;
              eop_q    <= 1'b0;
              done_q   <= grant_q;
              grant_q  <= '0;
              sel_q    <= '0;
              busy_q   <= 1'b0;
              frames_q <= frames_q + 16'd1;
              ptr_q    <= ptr_d;
              state_q  <= IDLE;
            end else begin
              real_q <= rd_data;
              idx_q  <= idx_d;
              sop_q  <= 1'b0;
              eop_q  <= (idx_q == LAST_IDX);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch_grant    = grant_q;
  assign ch_done     = done_q;
  assign rd_sel      = sel_q;
  assign sink_valid  = valid_q;
  assign sink_sop    = sop_q;
  assign sink_eop    = eop_q;
  assign sink_real   = real_q;
  assign sink_imag   = '0;
  assign sink_error  = SINK_ERR_NONE;
  assign busy        = busy_q;
  assign frames_done = frames_q;

endmodule
